// File: rtl/piso_pkg.sv
// piso_serializer shared types and helpers.
// State encoding, width limits and counter sizing.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int MAX_WIDTH = 32;

  // Counter must hold 0..WIDTH so the parity cycle fits.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a serial shift register.
// Optional parity cycle after the data bits: PIPO_PARITY_SER_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             serial_out,
  output logic             shift_enable,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
`ifdef PIPO_PARITY_SER_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q;
  logic [WIDTH-1:0] shifted;
  logic             head;
  logic             last;
  logic             hs;
`ifdef PIPO_PARITY_SER_EN
  logic             par_q, par_d;
`endif

  assign head    = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];
  assign shifted = MSB_FIRST ? (data_q << 1) : (data_q >> 1);

  assign last = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // armed_q keeps in_ready low until the first edge after reset.
  assign in_ready = armed_q && ((state_q == IDLE) || last);
  assign hs       = in_valid && in_ready;

  assign shift_enable = (state_q == SHIFT);
  assign busy         = (state_q == SHIFT);
  assign done         = last;

`ifdef PIPO_PARITY_SER_EN
  assign serial_out = (state_q == SHIFT) &&
                      ((cnt_q == LAST_CNT) ? par_q : head);
`else
  assign serial_out = (state_q == SHIFT) && head;
`endif

  // Next state: load on handshake, else finish or shift one bit.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef PIPO_PARITY_SER_EN
    par_d   = par_q;
`endif
    if (hs) begin
      state_d = SHIFT;
      data_d  = in_data;
      cnt_d   = '0;
`ifdef PIPO_PARITY_SER_EN
      par_d   = ^in_data;
`endif
    end else if (last) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      data_d = shifted;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // State registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
`ifdef PIPO_PARITY_SER_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
`ifdef PIPO_PARITY_SER_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (MSB-first and LSB-first).
// Expected bit streams come from a frame-level queue model.
module tb_piso_serializer;

  localparam int W = 4;

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic rdy_m, so_m, se_m, bz_m, dn_m;
  logic rdy_l, so_l, se_l, bz_l, dn_l;

  beat_t qm[$];
  beat_t ql[$];
  int    checks = 0;
  int    failures = 0;
  bit    armed = 1'b0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_m), .serial_out(so_m),
    .shift_enable(se_m), .busy(bz_m), .done(dn_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_l), .serial_out(so_l),
    .shift_enable(se_l), .busy(bz_l), .done(dn_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0b required=%0b",
               name, $time, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit has,
                         input beat_t e, input logic so,
                         input logic se, input logic bz,
                         input logic dn);
    chk({tag, ".serial_out"}, so, has ? e.b : 1'b0);
    chk({tag, ".shift_enable"}, se, has);
    chk({tag, ".busy"}, bz, has);
    chk({tag, ".done"}, dn, has ? e.last : 1'b0);
  endtask

  // Frame model: the word's bits in send order, optional parity.
  function automatic void push_frame(input logic [W-1:0] w);
    int n;
    n = W;
`ifdef PIPO_PARITY_SER_EN
    n = W + 1;
`endif
    for (int i = 0; i < W; i++) begin
      qm.push_back('{b: w[W-1-i], last: (i == n - 1)});
      ql.push_back('{b: w[i], last: (i == n - 1)});
    end
`ifdef PIPO_PARITY_SER_EN
    qm.push_back('{b: ^w, last: 1'b1});
    ql.push_back('{b: ^w, last: 1'b1});
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed = 1'b0;
    else armed = 1'b1;
  end

  // Monitor: pop one beat per cycle, then model any handshake.
  always @(negedge clk) begin
    beat_t em, el;
    bit    hm, hl, rexp;
    if (!reset_n) begin
      chk("rst.in_ready", rdy_m, 1'b0);
      chk("rst.serial_out", so_m | so_l, 1'b0);
      chk("rst.shift_enable", se_m | se_l, 1'b0);
      chk("rst.busy_done", bz_m | dn_m | bz_l | dn_l, 1'b0);
      qm.delete();
      ql.delete();
    end else begin
      hm = (qm.size() > 0);
      hl = (ql.size() > 0);
      em = '0;
      el = '0;
      if (hm) em = qm.pop_front();
      if (hl) el = ql.pop_front();
      chk_out("msb", hm, em, so_m, se_m, bz_m, dn_m);
      chk_out("lsb", hl, el, so_l, se_l, bz_l, dn_l);
      rexp = armed && (qm.size() == 0);
      chk("msb.in_ready", rdy_m, rexp);
      chk("lsb.in_ready", rdy_l, rexp);
      if (in_valid && rexp) push_frame(in_data);
    end
  end

  // Called just after a rising edge; returns just after the
  // rising edge that completed the handshake.
  task automatic send(input logic [W-1:0] w, input bit keep);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_m && n < 64);
    if (!rdy_m) begin
      failures++;
      $display("FAIL handshake_timeout word=%h", w);
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    in_data = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit k;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_release.in_ready", rdy_m, 1'b0);
    @(posedge clk);
    #1;
    chk("first_edge.in_ready", rdy_m, 1'b1);
    chk("first_edge.shift_enable", se_m, 1'b0);

    send(4'b1011, 1'b0);
    idle(6);
    send(4'b1000, 1'b0);
    idle(6);
    send(4'hA, 1'b1);
    send(4'h5, 1'b0);
    idle(8);
    send(4'b0111, 1'b0);
    idle(8);

    send(4'hF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst.shift_enable", se_m | se_l, 1'b0);
    chk("async_rst.serial_out", so_m | so_l, 1'b0);
    chk("async_rst.busy_done", bz_m | dn_m, 1'b0);
    chk("async_rst.in_ready", rdy_m, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    send(4'h3, 1'b0);
    idle(8);

    for (int i = 0; i < 150; i++) begin
      k = ($urandom_range(0, 2) != 0);
      send(W'($urandom), k);
      if (!k) idle($urandom_range(0, 3));
    end
    in_valid = 1'b0;

    n = 0;
    while ((qm.size() > 0 || ql.size() > 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (qm.size() > 0 || ql.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d", qm.size());
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 4-bit serial-in shift register.
- Accepts a parallel word over a valid/ready handshake.
- Drives the word one bit per clock on serial_out, with shift_enable asserted for exactly the data-bit cycles.
- serial_out and shift_enable connect straight to the shift register's serial_in and shift_enable.

Parameters:
- WIDTH, 4, data bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 sends in_data[WIDTH-1] first; 0 sends in_data[0] first.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a word on in_data
- in_data  input  WIDTH  parallel word; sampled only on handshake
- in_ready  output  1  block can accept a word this cycle
- serial_out  output  1  current serial bit; 0 when not shifting
- shift_enable  output  1  high on every cycle serial_out carries a valid bit
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse on the last bit cycle of a frame

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; shift register and bit counter cleared.
  - serial_out=0, shift_enable=0, busy=0, done=0, in_ready=0 while reset_n is low.
  - in_ready goes to 1 on the first clock after release.
- States are IDLE and SHIFT.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid && in_ready at a rising edge) loads in_data, sets bit_cnt=0 and moves to SHIFT.
- SHIFT:
  - serial_out = current head bit; shift_enable=1; busy=1.
  - Each clock the register shifts toward the head and bit_cnt increments.
- Latency: the first bit appears on serial_out the cycle after the handshake. A frame occupies exactly WIDTH consecutive shift_enable cycles.
- Last bit cycle (bit_cnt==WIDTH-1):
  - done=1 and in_ready=1.
  - With a handshake in that cycle: reload and stay in SHIFT, giving back-to-back frames with no idle gap. shift_enable stays high continuously.
  - Without a handshake: return to IDLE; serial_out=0 and shift_enable=0 next cycle.
- in_ready=0 in SHIFT except on the last bit cycle. in_valid during those cycles is ignored; the producer must hold in_data and in_valid.
- in_data is captured only at the handshake; later changes to in_data do not affect the frame in flight.
- bit_cnt width is $clog2(WIDTH+1) and never exceeds WIDTH-1 without PARITY_SER_EN.
- Reset asserted mid-frame: the frame is discarded and all outputs go to their reset values immediately. No partial frame resumes after release.
- in_valid held high continuously: frames stream back-to-back indefinitely.

Optional Feature:
- Macro: PIPO_PARITY_SER_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle carries even parity (XOR of the captured word) on serial_out, with shift_enable=1.
  - done and the back-to-back in_ready window move to this parity cycle. Frame length = WIDTH+1 cycles.
- Undefined: no parity cycle; the behaviour is exactly as above.

Decomposition:
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - constant MAX_WIDTH=32;
  - a function computing the bit counter width from WIDTH.
- No sub-module is needed. Shift register, counter and FSM live in piso_serializer. The parity XOR is a single reduction inside the `ifdef.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 cycles, release -> in_ready=1 one clock later; serial_out=0, shift_enable=0, busy=0.
- Single frame: WIDTH=4, MSB_FIRST=1, in_data=4'b1011 with one-cycle valid -> serial_out 1,0,1,1 on 4 consecutive cycles with shift_enable=1; done pulses on the 4th; downstream shift register q=4'b1011 after the frame.
- LSB-first: MSB_FIRST=0, in_data=4'b1000 -> serial_out sequence 0,0,0,1.
- Back-to-back: words 4'hA then 4'h5 with in_valid held -> 8 contiguous shift_enable cycles giving 1,0,1,0,0,1,0,1; no gap; done pulses at cycles 4 and 8.
- Reset mid-frame: assert reset_n=0 after 2 bits of 4'hF -> outputs 0 within the same cycle. After release, a new word 4'h3 gives exactly 0,0,1,1.
- Parity (PIPO_PARITY_SER_EN defined): in_data=4'b0111 -> 0,1,1,1 then parity bit 1; shift_enable high for 5 cycles; done on the 5th.
